// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin I/D arbiter onto one shared memory, with timeout
// Rev 1.0
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_READ,
   input  logic [ADDR_W-1:0] I_ADDRESS,
   output logic [DATA_W-1:0] I_READDATA,
   output logic              I_BUSYWAIT,
   input  logic              D_READ,
   input  logic              D_WRITE,
   input  logic [ADDR_W-1:0] D_ADDRESS,
   input  logic [DATA_W-1:0] D_WRITEDATA,
   output logic [DATA_W-1:0] D_READDATA,
   output logic              D_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT,
   output logic              ERROR
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_d;
   logic [TMR_W-1:0] timer;
   logic             req_i;
   logic             req_d;
   logic             grant_i;
   logic             grant_d;
   logic             in_grant;
   logic             timer_end;
   logic             finish;

   assign req_i      = I_READ;
   assign req_d      = D_READ | D_WRITE;
   assign I_BUSYWAIT = req_i & (state != DONE_I);
   assign D_BUSYWAIT = req_d & (state != DONE_D);
   assign in_grant   = (state == GRANT_I) || (state == GRANT_D);
   assign timer_end  = (timer == TMR_W'(TIMEOUT - 1));
   assign finish     = in_grant && (!MEM_BUSYWAIT || timer_end);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // On contention the port that did not win last time is served.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (req_i && (!req_d || last_d)) begin
               grant_i    = 1'b1;
               state_next = GRANT_I;
            end else if (req_d) begin
               grant_d    = 1'b1;
               state_next = GRANT_D;
            end
         end
         GRANT_I: if (finish) state_next = DONE_I;
         GRANT_D: if (finish) state_next = DONE_D;
         DONE_I:  state_next = IDLE;
         DONE_D:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         last_d        <= 1'b1;
         timer         <= '0;
         ERROR         <= 1'b0;
         MEM_READ      <= 1'b0;
         MEM_WRITE     <= 1'b0;
         MEM_ADDRESS   <= '0;
         MEM_WRITEDATA <= '0;
         I_READDATA    <= '0;
         D_READDATA    <= '0;
      end else if (grant_i) begin
         last_d        <= 1'b0;
         timer         <= '0;
         MEM_READ      <= 1'b1;
         MEM_WRITE     <= 1'b0;
         MEM_ADDRESS   <= I_ADDRESS;
         MEM_WRITEDATA <= '0;
      end else if (grant_d) begin
         last_d        <= 1'b1;
         timer         <= '0;
         MEM_READ      <= ~D_WRITE;
         MEM_WRITE     <= D_WRITE;
         MEM_ADDRESS   <= D_ADDRESS;
         MEM_WRITEDATA <= D_WRITEDATA;
      end else if (in_grant) begin
         timer <= timer + 1'b1;
         if (finish) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            // An aborted read returns zero rather than whatever is on the bus.
            if (MEM_READ) begin
               if (state == GRANT_I) begin
                  I_READDATA <= MEM_BUSYWAIT ? '0 : MEM_READDATA;
               end else begin
                  D_READDATA <= MEM_BUSYWAIT ? '0 : MEM_READDATA;
               end
            end
            if (MEM_BUSYWAIT) begin
               ERROR <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : directed and randomized checks of mem_arbiter against a
// transaction-level reference of the shared memory and the arbitration rules.
module tb_mem_arbiter;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          CLK, RESET;
   logic          I_READ, I_BUSYWAIT;
   logic [AW-1:0] I_ADDRESS;
   logic [DW-1:0] I_READDATA;
   logic          D_READ, D_WRITE, D_BUSYWAIT;
   logic [AW-1:0] D_ADDRESS;
   logic [DW-1:0] D_WRITEDATA, D_READDATA;
   logic          MEM_READ, MEM_WRITE, MEM_BUSYWAIT, ERROR;
   logic [AW-1:0] MEM_ADDRESS;
   logic [DW-1:0] MEM_WRITEDATA, MEM_READDATA;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
      .ERROR(ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec, n_err;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Memory device: holds BUSYWAIT for 'lat' strobe cycles, then completes.
   logic [DW-1:0] dev_mem [64];
   logic [DW-1:0] ref_mem [64];
   int            lat, dev_cnt;
   logic [AW-1:0] dev_addr;
   logic          dev_wr;

   initial begin
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = '0;
      dev_cnt      = 0;
      dev_addr     = '0;
      dev_wr       = 1'b0;
      forever begin
         @(negedge CLK);
         if (MEM_READ || MEM_WRITE) begin
            if (dev_cnt < lat) begin
               MEM_BUSYWAIT = 1'b1;
               dev_cnt++;
            end else begin
               MEM_BUSYWAIT = 1'b0;
               dev_addr     = MEM_ADDRESS;
               dev_wr       = MEM_WRITE;
               if (MEM_WRITE) begin
                  dev_mem[MEM_ADDRESS] = MEM_WRITEDATA;
                  MEM_READDATA = $urandom;
               end else begin
                  MEM_READDATA = dev_mem[MEM_ADDRESS];
               end
            end
         end else begin
            MEM_BUSYWAIT = 1'b0;
            dev_cnt      = 0;
            MEM_READDATA = $urandom;
         end
      end
   end

   // Requester agents and reference model.
   typedef struct packed {
      logic          wr;
      logic          both;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [3:0]    gap;
   } txn_t;

   txn_t          iq[$], dq[$], i_cur, d_cur;
   bit            i_act, d_act, rand_lat;
   int            i_foreign, d_foreign, i_gapc, d_gapc, cyc;
   int            order[$], done_at[$];
   logic [DW-1:0] i_exp, d_exp;

   function automatic txn_t mk(input logic wr, input logic both, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input int gap);
      txn_t t;
      t.wr = wr; t.both = both; t.addr = a; t.wd = d; t.gap = 4'(gap);
      return t;
   endfunction

   function automatic int ord(input int k);
      return (k < order.size()) ? order[k] : 9;
   endfunction

   function automatic int dat(input int k);
      return (k < done_at.size()) ? done_at[k] : -100;
   endfunction

   task automatic step();
      @(negedge CLK);
      cyc++;
      if (rand_lat) lat = $urandom_range(0, 4);
      if (i_act && !I_BUSYWAIT) begin
         i_exp = ref_mem[i_cur.addr];
         check("i_rdata", I_READDATA, i_exp);
         check("i_mem_addr", 32'(dev_addr), 32'(i_cur.addr));
         check("i_mem_op", 32'(dev_wr), 32'd0);
         check("i_other_stalled", 32'(D_BUSYWAIT), 32'(D_READ | D_WRITE));
         check("i_wait", 32'(i_foreign > 1), 32'd0);
         if (d_act) d_foreign++;
         order.push_back(0);
         done_at.push_back(cyc);
         i_act = 0; I_READ = 1'b0; i_gapc = 0;
      end
      if (d_act && !D_BUSYWAIT) begin
         if (d_cur.wr) begin
            ref_mem[d_cur.addr] = d_cur.wd;
         end else begin
            d_exp = ref_mem[d_cur.addr];
         end
         check("d_rdata", D_READDATA, d_exp);
         check("d_mem_addr", 32'(dev_addr), 32'(d_cur.addr));
         check("d_mem_op", 32'(dev_wr), 32'(d_cur.wr));
         check("d_other_stalled", 32'(I_BUSYWAIT), 32'(I_READ));
         check("d_wait", 32'(d_foreign > 1), 32'd0);
         if (i_act) i_foreign++;
         order.push_back(1);
         done_at.push_back(cyc);
         d_act = 0; D_READ = 1'b0; D_WRITE = 1'b0; d_gapc = 0;
      end
      if (!i_act && iq.size() > 0) begin
         if (i_gapc >= int'(iq[0].gap)) begin
            i_cur = iq.pop_front();
            i_act = 1; i_foreign = 0;
            I_READ = 1'b1; I_ADDRESS = i_cur.addr;
         end else begin
            i_gapc++;
         end
      end
      if (!d_act && dq.size() > 0) begin
         if (d_gapc >= int'(dq[0].gap)) begin
            d_cur = dq.pop_front();
            d_act = 1; d_foreign = 0;
            D_WRITE = d_cur.wr; D_READ = ~d_cur.wr | d_cur.both;
            D_ADDRESS = d_cur.addr; D_WRITEDATA = d_cur.wd;
         end else begin
            d_gapc++;
         end
      end
   endtask

   task automatic run(input int maxc);
      int c;
      c = 0;
      while ((i_act || d_act || iq.size() > 0 || dq.size() > 0) && c < maxc) begin
         step();
         c++;
      end
      check("run_drained", 32'(i_act || d_act || iq.size() > 0 || dq.size() > 0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int            rd, lo, touch, k;
      bit            done;
      logic [DW-1:0] got;

      n_vec = 0; n_err = 0; cyc = 0; lat = 0; rand_lat = 0;
      i_act = 0; d_act = 0; i_gapc = 0; d_gapc = 0; i_foreign = 0; d_foreign = 0;
      i_exp = '0; d_exp = '0;
      RESET = 1'b0; I_READ = 1'b0; I_ADDRESS = '0;
      D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
      for (int i = 0; i < 64; i++) begin
         dev_mem[i] = $urandom;
         ref_mem[i] = dev_mem[i];
      end

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_error", 32'(ERROR), 32'd0);
      check("rst_mem_read", 32'(MEM_READ), 32'd0);
      check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
      check("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
      check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
      check("rst_i_rdata", I_READDATA, 32'd0);
      check("rst_d_rdata", D_READDATA, 32'd0);
      RESET = 1'b1;

      // Simultaneous I read and D write after reset: I wins
      lat = 2;
      order.delete(); done_at.delete();
      iq.push_back(mk(0, 0, 6'h04, 32'd0, 0));
      dq.push_back(mk(1, 0, 6'h10, 32'hDEADBEEF, 0));
      run(100);
      check("t2_first_I", 32'(ord(0)), 32'd0);
      check("t2_second_D", 32'(ord(1)), 32'd1);
      check("t2_mem_written", dev_mem[16], 32'hDEADBEEF);

      // Continuous requests from both ports alternate with one IDLE gap
      order.delete(); done_at.delete();
      for (int i = 0; i < 3; i++) begin
         iq.push_back(mk(0, 0, 6'($urandom_range(0, 63)), 32'd0, 0));
         dq.push_back(mk(1'($urandom_range(0, 1)), 0, 6'($urandom_range(0, 63)), $urandom, 0));
      end
      run(200);
      for (int i = 0; i < 6; i++) check("t3_order", 32'(ord(i)), 32'(i % 2));
      for (int i = 1; i < 6; i++) check("t3_spacing", 32'(dat(i) - dat(i - 1)), 32'(lat + 3));

      // Single I read, three busy cycles
      lat = 3;
      dev_mem[4] = 32'h00040005; ref_mem[4] = 32'h00040005;
      @(negedge CLK);
      I_READ = 1'b1; I_ADDRESS = 6'h04;
      #1 check("t1_stall_same_cycle", 32'(I_BUSYWAIT), 32'd1);
      rd = 0; lo = 0; touch = 0; got = '0;
      for (int j = 0; j < 20; j++) begin
         @(negedge CLK);
         if (MEM_READ) rd++;
         if (MEM_WRITE || D_BUSYWAIT) touch++;
         if (I_READ) begin
            if (!I_BUSYWAIT) begin
               lo++; got = I_READDATA;
            end else if (lo > 0) begin
               I_READ = 1'b0;
            end
         end
      end
      check("t1_mem_read_cycles", 32'(rd), 32'd4);
      check("t1_busywait_low_cycles", 32'(lo), 32'd1);
      check("t1_rdata", got, 32'h00040005);
      check("t1_rdata_hold", I_READDATA, 32'h00040005);
      check("t1_d_untouched", 32'(touch), 32'd0);
      check("t1_d_rdata", D_READDATA, d_exp);
      i_exp = 32'h00040005;

      // Requester inputs changed mid-GRANT are ignored
      lat = 3;
      @(negedge CLK);
      D_WRITE = 1'b1; D_READ = 1'b0; D_ADDRESS = 6'h21; D_WRITEDATA = 32'h12345678;
      k = 0;
      do begin
         @(negedge CLK); k++;
      end while (!MEM_WRITE && k < 5);
      check("t6_granted", 32'(MEM_WRITE), 32'd1);
      D_ADDRESS = 6'h0A; D_WRITEDATA = 32'hFFFF0000;
      done = 0;
      for (int j = 0; j < 10 && !done; j++) begin
         @(negedge CLK);
         if (!D_BUSYWAIT) begin
            done = 1; D_WRITE = 1'b0;
         end else begin
            check("t6_strobe", 32'(MEM_WRITE), 32'd1);
            check("t6_addr_latched", 32'(MEM_ADDRESS), 32'h21);
            check("t6_wdata_latched", MEM_WRITEDATA, 32'h12345678);
         end
      end
      check("t6_done", 32'(done), 32'd1);
      ref_mem[6'h21] = 32'h12345678;
      check("t6_mem_target", dev_mem[6'h21], ref_mem[6'h21]);
      check("t6_mem_other", dev_mem[6'h0A], ref_mem[6'h0A]);

      // Randomized traffic
      rand_lat = 1;
      for (int i = 0; i < 40; i++) begin
         iq.push_back(mk(0, 0, 6'($urandom_range(0, 7)), 32'd0, $urandom_range(0, 3)));
         dq.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         6'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3)));
      end
      run(3000);
      rand_lat = 0;
      check("rand_no_error", 32'(ERROR), 32'd0);

      // Timeout on a D read, then normal traffic resumes
      lat = 1;
      dev_mem[63] = 32'hA5A50F0F; ref_mem[63] = 32'hA5A50F0F;
      dq.push_back(mk(0, 0, 6'h3F, 32'd0, 0));
      run(50);
      lat = 100000;
      @(negedge CLK);
      D_READ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = 6'h3F;
      rd = 0; done = 0; got = 32'hFFFFFFFF;
      for (int j = 0; j < 40; j++) begin
         @(negedge CLK);
         if (MEM_READ) rd++;
         if (D_READ && !D_BUSYWAIT) begin
            got = D_READDATA; done = 1; D_READ = 1'b0;
         end
      end
      check("t4_done", 32'(done), 32'd1);
      check("t4_mem_read_cycles", 32'(rd), 32'(TO));
      check("t4_rdata_zero", got, 32'd0);
      check("t4_strobe_dropped", 32'(MEM_READ), 32'd0);
      check("t4_error_set", 32'(ERROR), 32'd1);
      d_exp = '0;
      lat = 2;
      iq.push_back(mk(0, 0, 6'h3F, 32'd0, 0));
      run(50);
      check("t4_error_sticky", 32'(ERROR), 32'd1);

      // Reset in the second GRANT cycle of a D write
      lat = 100000;
      @(negedge CLK);
      D_WRITE = 1'b1; D_READ = 1'b0; D_ADDRESS = 6'h05; D_WRITEDATA = 32'hCAFEF00D;
      @(negedge CLK);
      check("t5_grant1_write", 32'(MEM_WRITE), 32'd1);
      @(negedge CLK);
      RESET = 1'b0; I_READ = 1'b1; I_ADDRESS = 6'h07;
      @(negedge CLK);
      check("t5_write_dropped", 32'(MEM_WRITE), 32'd0);
      check("t5_read_low", 32'(MEM_READ), 32'd0);
      check("t5_error_clear", 32'(ERROR), 32'd0);
      check("t5_addr_clear", 32'(MEM_ADDRESS), 32'd0);
      check("t5_i_rdata_clear", I_READDATA, 32'd0);
      check("t5_i_stalled", 32'(I_BUSYWAIT), 32'd1);
      check("t5_d_stalled", 32'(D_BUSYWAIT), 32'd1);
      check("t5_no_commit", dev_mem[5], ref_mem[5]);
      i_exp = '0; d_exp = '0;
      RESET = 1'b1;
      lat = 1;
      order.delete(); done_at.delete();
      i_cur = mk(0, 0, 6'h07, 32'd0, 0);          i_act = 1; i_foreign = 0;
      d_cur = mk(1, 0, 6'h05, 32'hCAFEF00D, 0);   d_act = 1; d_foreign = 0;
      run(100);
      check("t5_first_I", 32'(ord(0)), 32'd0);
      check("t5_second_D", 32'(ord(1)), 32'd1);
      check("t5_error_stays_clear", 32'(ERROR), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
